sdram_audio_streamer: RTL

//  Downstream consumer of the SD-card RAM loader. Reads 16-bit PCM words from the half of SDRAM not being filled.

---
 rtl/audio_stream_pkg.sv | 6 +
 rtl/sdram_audio_streamer_if.sv | 12 +
 rtl/sample_fifo.sv | 68 ++++++
 rtl/sdram_audio_streamer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared types and widths for the SDRAM audio streamer and its sample FIFO.
package audio_stream_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, SWAP, STALL} streamer_state_e;
   localparam int RAM_ADDR_W = 25;
   localparam int SAMPLE_W   = 16;
endpackage

// File: rtl/sdram_audio_streamer_if.sv
// SDRAM read port of the audio streamer: request/accept handshake plus read-data strobe.
interface sdram_audio_streamer_if;
   import audio_stream_pkg::*;
   logic                  ram_re;
   logic [RAM_ADDR_W-1:0] ram_address;
   logic                  ram_op_begun;
   logic [SAMPLE_W-1:0]   ram_rdata;
   logic                  ram_rdata_valid;

   modport master (output ram_re, ram_address, input ram_op_begun, ram_rdata, ram_rdata_valid);
   modport slave  (input ram_re, ram_address, output ram_op_begun, ram_rdata, ram_rdata_valid);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with one- or two-word pop; the head and the word behind it are
// presented combinationally so a sample tick can be served in the cycle it arrives.
module sample_fifo
   import audio_stream_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                push,
   input  logic [SAMPLE_W-1:0] push_data,
   input  logic                pop,
   input  logic                pop_two,
   output logic [SAMPLE_W-1:0] rd_data0,
   output logic [SAMPLE_W-1:0] rd_data1,
   output logic [CNT_W-1:0]    count,
   output logic                empty,
   output logic                full
);
   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [SAMPLE_W-1:0] tap [2];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [CNT_W-1:0]    pop_n;
   logic                do_push;

   assign do_push = push && !full;
   assign pop_n   = !pop ? '0 : (pop_two ? CNT_W'(2) : CNT_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_n);
         count_reg  <= count_reg + CNT_W'(do_push) - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr_reg] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_tap
         assign tap[gi] = mem[rd_ptr_reg + PTR_W'(gi)];
      end
   endgenerate

   assign rd_data0 = tap[0];
   assign rd_data1 = tap[1];
   assign count    = count_reg;
   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(DEPTH));
endmodule

// File: rtl/sdram_audio_streamer.sv
// Ping-pong SDRAM audio player: reads the half not being filled into a FIFO and emits one
// sample per sample_tick. Define STREAMER_STEREO_EN to emit an L/R word pair per tick.
module sdram_audio_streamer
   import audio_stream_pkg::*;
#(
   parameter int HALF_ADDR_W = 23,
   parameter int FIFO_DEPTH  = 8,
   parameter int UNDERRUN_W  = 16
)(
   input  logic                  clk50,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  fill_ready,
   output logic                  fill_half,
   sdram_audio_streamer_if.master ram,
   input  logic                  sample_tick,
   output logic [SAMPLE_W-1:0]   sample_l,
   output logic [SAMPLE_W-1:0]   sample_r,
   output logic                  sample_valid,
   output logic [UNDERRUN_W-1:0] underrun_cnt,
   output logic                  playing
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef STREAMER_STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif

   streamer_state_e        state_reg, state_next;
   logic                   play_half_reg, play_half_next;
   logic                   fill_half_reg, fill_half_next;
   logic [HALF_ADDR_W-1:0] word_ptr_reg, word_ptr_next;
   logic                   req_active, push, flush, pop, enough;
   logic [SAMPLE_W-1:0]    head_word, next_word;
   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_empty, fifo_full;
   logic [SAMPLE_W-1:0]    sample_l_reg, sample_r_reg;
   logic                   sample_valid_reg;
   logic [UNDERRUN_W-1:0]  underrun_reg;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         play_half_reg <= 1'b0;
         fill_half_reg <= 1'b0;
         word_ptr_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         play_half_reg <= play_half_next;
         fill_half_reg <= fill_half_next;
         word_ptr_reg  <= word_ptr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      play_half_next = play_half_reg;
      fill_half_next = fill_half_reg;
      word_ptr_next  = word_ptr_reg;
      req_active     = 1'b0;
      push           = 1'b0;
      flush          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && fill_ready) begin
               play_half_next = 1'b0;
               fill_half_next = 1'b1;
               word_ptr_next  = '0;
               state_next     = REQ;
            end
         end
         REQ: begin
            req_active = !fifo_full;
            if (req_active && ram.ram_op_begun) begin
               state_next = WAIT;
            end else if (!start) begin
               state_next = IDLE;
               flush      = 1'b1;
            end
         end
         WAIT: begin
            // An accepted read is always completed, even when start has dropped.
            if (ram.ram_rdata_valid) begin
               push = start;
               if (!start) begin
                  state_next = IDLE;
                  flush      = 1'b1;
               end else if (word_ptr_reg == '1) begin
                  state_next = SWAP;
               end else begin
                  word_ptr_next = word_ptr_reg + HALF_ADDR_W'(1);
                  state_next    = REQ;
               end
            end
         end
         SWAP, STALL: begin
            if (!start) begin
               state_next = IDLE;
               flush      = 1'b1;
            end else if (fill_ready) begin
               play_half_next = ~play_half_reg;
               fill_half_next = play_half_reg;
               word_ptr_next  = '0;
               state_next     = REQ;
            end else begin
               state_next = STALL;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk50),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data (ram.ram_rdata),
      .pop       (pop),
      .pop_two   (STEREO),
      .rd_data0  (head_word),
      .rd_data1  (next_word),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign enough = STEREO ? (fifo_count >= CNT_W'(2)) : !fifo_empty;
   assign pop    = sample_tick && enough;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         sample_l_reg     <= '0;
         sample_r_reg     <= '0;
         sample_valid_reg <= 1'b0;
         underrun_reg     <= '0;
      end else begin
         sample_valid_reg <= sample_tick;
         if (sample_tick) begin
            if (enough) begin
               sample_l_reg <= head_word;
               sample_r_reg <= STEREO ? next_word : head_word;
            end else begin
               sample_l_reg <= '0;
               sample_r_reg <= '0;
               if (underrun_reg != '1)
                  underrun_reg <= underrun_reg + UNDERRUN_W'(1);
            end
         end
      end
   end

   assign ram.ram_re      = req_active;
   assign ram.ram_address = RAM_ADDR_W'({play_half_reg, word_ptr_reg});
   assign fill_half       = fill_half_reg;
   assign sample_l        = sample_l_reg;
   assign sample_r        = sample_r_reg;
   assign sample_valid    = sample_valid_reg;
   assign underrun_cnt    = underrun_reg;
   assign playing         = (state_reg != IDLE);
endmodule
